// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin arbitration, one bit per CLK, registered outputs.
// Define UART_TX_SCHED_TWO_STOP_EN for two stop bits.
module uart_tx_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    input  logic [WIDTH-1:0] REQ0_DATA,
    input  logic             REQ1_VALID,
    input  logic [WIDTH-1:0] REQ1_DATA,
    input  logic             PAR_EN,
    input  logic             PAR_TYPE,
    output logic             REQ0_ACK,
    output logic             REQ1_ACK,
    output logic             TX_OUT,
    output logic             BUSY,
    output logic             GRANT_ID
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_par_en, r_par_type;
    logic             r_prio;
    logic             r_grant, r_ack0, r_ack1, r_tx, r_busy;
    logic             w_stop_last, w_accept, w_win, w_tx_nxt;

`ifdef UART_TX_SCHED_TWO_STOP_EN
    logic r_stop_cnt;
    assign w_stop_last = r_stop_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_stop_cnt <= 1'b0;
        else      r_stop_cnt <= (r_state == S_STOP) ? ~r_stop_cnt : 1'b0;
    end
`else
    assign w_stop_last = 1'b1;
`endif

    // Acceptance happens from IDLE or on the last stop cycle, giving back-to-back frames.
    assign w_accept = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_last))
                      && (REQ0_VALID || REQ1_VALID);
    // r_prio holds the favoured requester for a tie.
    assign w_win    = (REQ0_VALID && REQ1_VALID) ? r_prio : REQ1_VALID;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_START;
            S_START: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = '0;
            end
            S_DATA: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_stop_last) w_state_nxt = w_accept ? S_START : S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        // TX is registered, so it is derived from the state being entered.
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_data[w_cnt_nxt];
            S_PARITY: w_tx_nxt = (^r_data) ^ r_par_type;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_prio     <= 1'b0;
            r_grant    <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_ack0 <= w_accept && !w_win;
            r_ack1 <= w_accept && w_win;
            r_tx   <= w_tx_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_data     <= w_win ? REQ1_DATA : REQ0_DATA;
                r_par_en   <= PAR_EN;
                r_par_type <= PAR_TYPE;
                r_grant    <= w_win;
                r_prio     <= ~w_win;
            end
        end
    end

    assign REQ0_ACK = r_ack0;
    assign REQ1_ACK = r_ack1;
    assign TX_OUT   = r_tx;
    assign BUSY     = r_busy;
    assign GRANT_ID = r_grant;
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Two-requester UART transmit controller. It arbitrates between two parallel-data sources and sequences one complete frame at a time onto the serial line: start, data, optional parity, stop.
- Per-frame configuration (parity enable/type) and data are latched at frame acceptance, so changes mid-frame never disturb the running frame.
- Sits between the host-side data producers and the TX pad. CLK is the bit-rate clock: one bit per CLK cycle.

Parameters:
- WIDTH, 8, data bits per frame (2..16).

Ports:
- CLK  in  1  bit-rate clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  requester 0 has a byte; held high with REQ0_DATA stable until REQ0_ACK.
- REQ0_DATA  in  WIDTH  requester 0 payload.
- REQ1_VALID  in  1  requester 1 has a byte (same rules as requester 0).
- REQ1_DATA  in  WIDTH  requester 1 payload.
- PAR_EN  in  1  parity enable, sampled at acceptance.
- PAR_TYPE  in  1  0 = even parity, 1 = odd parity, sampled at acceptance.
- REQ0_ACK  out  1  one-cycle pulse: requester 0 word accepted.
- REQ1_ACK  out  1  one-cycle pulse: requester 1 word accepted.
- TX_OUT  out  1  serial line, idle high.
- BUSY  out  1  high while a frame is on the line.
- GRANT_ID  out  1  source of the frame currently transmitting.

Behaviour:
- Reset: state IDLE, TX_OUT=1, BUSY=0, ACKs=0, GRANT_ID=0, bit counter=0, round-robin pointer set to favour REQ0. All outputs are registered. Reset asserted mid-frame aborts immediately (asynchronously) and the partial frame is discarded, with no ACK re-issue.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance point:
  - Occurs at a clock edge when state is IDLE, or in the final STOP cycle, and at least one VALID is high.
  - At that edge the block latches data, PAR_EN, PAR_TYPE and GRANT_ID; the winner's ACK is set for exactly the next cycle (the first START cycle); the state goes to START.
- Arbitration:
  - Only one VALID high: that requester wins.
  - Both VALIDs high: the requester not granted last wins.
  - The pointer updates only on a grant.
- START: TX_OUT=0 for one cycle, then DATA.
- DATA:
  - TX_OUT = latched data bit[cnt], LSB first, for WIDTH cycles.
  - cnt runs 0..WIDTH-1, then resets to 0.
  - Next state is PARITY if the latched PAR_EN is set, else STOP.
- PARITY:
  - Even parity: TX_OUT = XOR-reduction of the latched data.
  - Odd parity: TX_OUT = its inverse.
  - Lasts one cycle, then STOP.
- STOP:
  - TX_OUT=1.
  - If any VALID is high at the final STOP edge, accept and go to START (back-to-back, no idle cycle); otherwise go to IDLE.
- BUSY is high in START, DATA, PARITY and STOP, and low only in IDLE.
- Frame length: 1 + WIDTH + PAR_EN + stop cycles.
- VALID dropped before ACK: no frame is started and no ACK is issued.
- Input changes on PAR_EN, PAR_TYPE or DATA after acceptance are ignored until the next acceptance.

Optional Feature:
- Macro: UART_TX_SCHED_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles. A 1-bit stop counter is added, and acceptance is evaluated only in the second STOP cycle.
- Undefined: a single STOP cycle; no stop counter is synthesized.

Test Plan:
- Reset, then REQ0_VALID=1 with REQ0_DATA=0xA5, PAR_EN=1, PAR_TYPE=0 → REQ0_ACK pulses once in the first START cycle; TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; BUSY high for exactly those 11 cycles; then TX_OUT=1 and BUSY=0.
- Same as the first scenario but PAR_TYPE=1 → parity cycle TX_OUT=1. With PAR_EN=0 instead → 10-cycle frame with no parity slot.
- REQ0 (0x3C) and REQ1 (0xC3) both valid from IDLE after reset, both held valid → REQ0 frame first, then REQ1 frame starting the cycle after STOP (no idle cycle), then REQ0 again; GRANT_ID toggles 0,1,0.
- PAR_EN toggled from 1 to 0 during DATA of a 0xFF frame → frame still includes its parity bit (0, even parity); the next frame uses the new setting.
- RST pulled low during DATA bit 3 → TX_OUT=1, BUSY=0, ACKs=0 without waiting for a CLK edge. After release with REQ1_VALID held → REQ1 accepted, and the pointer favours REQ0 on the following tie.
- With UART_TX_SCHED_TWO_STOP_EN defined and 0x00, PAR_EN=0 → TX_OUT = 0, eight 0s, 1, 1 (11 cycles); back-to-back acceptance occurs only at the second stop edge.
